// File: rtl/cla_serial_subtractor.sv
// -----------------------------------------------------------------------------
// cla_serial_subtractor
//
// Multi-cycle subtractor: diff = a - b - b_in (modulo 2^WIDTH), evaluated one
// 4-bit carry-lookahead group per clock. The inter-group carry is registered, so
// the longest combinational path is a single 4-bit lookahead group.
//
// Subtraction is done as a + ~b + ~b_in. The carry held between groups is the
// inverted borrow: the final unsigned borrow out is ~carry.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b, b_in valid
//   in_ready   block can accept operands (high only while idle)
//   a, b       minuend / subtrahend, WIDTH bits
//   b_in       borrow in
//   out_valid  diff / b_out / ovf valid
//   out_ready  consumer accepts the result
//   diff       a - b - b_in, modulo 2^WIDTH
//   b_out      unsigned borrow out (1 when a < b + b_in)
//   ovf        signed overflow of the subtraction
// -----------------------------------------------------------------------------
module cla_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int NG   = WIDTH / 4;
    localparam int IDXW = (NG > 1) ? $clog2(NG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Returns carries {c4, c3, c2, c1, c0} of one 4-bit lookahead group.
    function automatic logic [4:0] cla4_carries(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c0
    );
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              b_out_q, b_out_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [3:0]        grp_a_s;
    logic [3:0]        grp_b_s;
    logic [3:0]        grp_g_s;
    logic [3:0]        grp_p_s;
    logic [4:0]        grp_c_s;
    logic [3:0]        grp_sum_s;

    // Lookahead evaluation of the group currently selected by idx_q.
    always_comb begin
        grp_a_s   = a_q[{idx_q, 2'b00} +: 4];
        grp_b_s   = b_q[{idx_q, 2'b00} +: 4];
        grp_g_s   = grp_a_s & ~grp_b_s;
        grp_p_s   = grp_a_s ^ ~grp_b_s;
        grp_c_s   = cla4_carries(grp_g_s, grp_p_s, carry_q);
        grp_sum_s = grp_p_s ^ grp_c_s[3:0];
    end

    // Next-state and next-output logic of the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        diff_d      = diff_q;
        b_out_d     = b_out_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ~b_in;
                    idx_d   = {IDXW{1'b0}};
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                diff_d[{idx_q, 2'b00} +: 4] = grp_sum_s;
                carry_d                     = grp_c_s[4];
                idx_d                       = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
                if (idx_q == IDXW'(NG - 1)) begin
                    // Last group: the sum's top bit is the result MSB.
                    b_out_d = ~grp_c_s[4];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                            && (grp_sum_s[3] != a_q[WIDTH-1]);
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            idx_q       <= {IDXW{1'b0}};
            diff_q      <= {WIDTH{1'b0}};
            b_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            diff_q      <= diff_d;
            b_out_q     <= b_out_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign b_out     = b_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// -----------------------------------------------------------------------------
// Testbench for cla_serial_subtractor (WIDTH=16). A driver issues operands and
// pushes the expected result into a scoreboard queue at acceptance; a separate
// monitor pops and compares on every result handshake, and also checks latency
// and that outputs hold while out_ready is low.
// -----------------------------------------------------------------------------
module tb_cla_serial_subtractor;

    localparam int W  = 16;
    localparam int NG = W / 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rdy_mode = 0;

    cla_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // out_ready driver: 0 = held high, 1 = held low, otherwise random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: latency, hold stability and scoreboard comparison.
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic [17:0]  pout = 18'h0;
    exp_t         e;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (out_valid && !pv)
                chk("latency", 32'(cyc - acc_cyc), 32'(NG));
            if (out_valid && pv && !pr) begin
                chk("hold_outputs", {14'h0, diff, b_out, ovf}, {14'h0, pout});
                chk("hold_in_ready_low", {31'h0, in_ready}, 32'h0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks = checks + 1;
                    $display("FAIL unexpected_result: got diff=%h b_out=%b ovf=%b expected none",
                             diff, b_out, ovf);
                end else begin
                    e = sb.pop_front();
                    chk("result", {14'h0, diff, b_out, ovf}, {14'h0, e.d, e.bo, e.ov});
                end
            end
            pv   = out_valid;
            pr   = out_ready;
            pout = {diff, b_out, ovf};
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbi,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
        int   n = 0;
        logic acc = 1'b0;
        exp_t x;
        a = ta;
        b = tb_v;
        b_in = tbi;
        in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n = n + 1;
        end
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        b_in = 1'($urandom_range(0, 1));
        if (!acc) begin
            checks = checks + 1;
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles expected 1");
        end else begin
            acc_cyc = cyc;
            x.d = ed;
            x.bo = eb;
            x.ov = eo;
            sb.push_back(x);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        if (n >= 200) begin
            checks = checks + 1;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        checks = checks + 1;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbi;
        logic [16:0]  r17;
        int           sr;

        rst_n = 1'b0;
        in_valid = 1'b0;
        a = 16'h0;
        b = 16'h0;
        b_in = 1'b0;
        #12;
        chk("reset_state", {12'h0, in_ready, out_valid, diff, b_out, ovf},
            {12'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic, full-ripple borrow and overflow vectors.
        send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        drain();
        chk("diff_held_in_idle", {16'h0, diff}, 32'h0000_1000);
        send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        send(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        send(16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1);
        send(16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1);
        drain();

        // Consumer stalls: outputs must hold while out_ready is low.
        rdy_mode = 1;
        send(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        repeat (NG + 6) @(posedge clk);
        #1;
        rdy_mode = 0;
        drain();

        // Asynchronous reset in the middle of the computation.
        send(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_calc_reset", {12'h0, in_ready, out_valid, diff, b_out, ovf},
            {12'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NG + 2) @(posedge clk);
        #1;
        chk("no_result_after_reset", {31'h0, out_valid}, 32'h0);
        send(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);
        drain();

        // Random operands with random consumer back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 200; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rbi = 1'($urandom_range(0, 1));
            r17 = {1'b0, ra} - {1'b0, rb} - {16'h0, rbi};
            sr  = int'($signed(ra)) - int'($signed(rb)) - int'(rbi);
            send(ra, rb, rbi, r17[15:0], r17[16], (sr > 32767) || (sr < -32768));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
